// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - state encodings and defaults shared by the SRAM clear arbiter
// HST_* states exist only when SRAM_ARB_HOST_EN is defined.
package sram_arb_pkg;

  localparam logic [7:0] CLR_VALUE_DEFAULT = 8'h00;

  typedef enum logic [2:0] {
    CLR_SETUP  = 3'd0,
    CLR_WRITE  = 3'd1,
    IDLE       = 3'd2
`ifdef SRAM_ARB_HOST_EN
    ,
    HST_SETUP  = 3'd3,
    HST_ACCESS = 3'd4
`endif
  } arb_state_t;

endpackage

// File: rtl/sram_clr_counter.sv
// rtl/sram_clr_counter.sv - clear sweep address counter with end-address compare
// Memory size is captured on start so the sweep length cannot change mid-run.
module sram_clr_counter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = 21
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              start,
  input  logic              step,
  input  logic              mem_size,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] r_addr;
  logic              r_mem_size;
  logic [ADDR_W-1:0] w_end_addr;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_addr     <= '0;
      r_mem_size <= 1'b0;
    end else if (start) begin
      r_addr     <= '0;
      r_mem_size <= mem_size;
    end else if (step) begin
      r_addr     <= r_addr + ADDR_ONE;
    end
  end

  // A 1 MB part ends at the halfway point: all ones with the top bit cleared.
  always_comb begin
    w_end_addr = '1;
    if (r_mem_size) begin
      w_end_addr[ADDR_W-1] = 1'b0;
    end
  end

  assign addr = r_addr;
  assign last = (r_addr == w_end_addr);

endmodule

// File: rtl/sram_clear_arb.sv
// rtl/sram_clear_arb.sv - SRAM clear sweep plus core/host access arbiter
// Host port and HST states are built only when SRAM_ARB_HOST_EN is defined.
module sram_clear_arb
  import sram_arb_pkg::*;
#(
  parameter int         ADDR_W    = 21,
  parameter logic [7:0] CLR_VALUE = CLR_VALUE_DEFAULT
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              clr_start,
  input  logic              mem_size,
  output logic              busy,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [7:0]        core_din,
  output logic [7:0]        core_dout,
  input  logic              core_ce_n,
  input  logic              core_oe_n,
  input  logic              core_we_n,
  input  logic              hst_req,
  input  logic              hst_we,
  input  logic [ADDR_W-1:0] hst_addr,
  input  logic [7:0]        hst_din,
  output logic              hst_ack,
  output logic [7:0]        hst_dout,
  output logic [ADDR_W-1:0] sram_a,
  output logic [7:0]        sram_dout,
  input  logic [7:0]        sram_din,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              conflict
);

  arb_state_t        r_state;
  arb_state_t        w_next;
  logic              r_busy;
  logic [7:0]        r_core_dout;
  logic [ADDR_W-1:0] w_clr_addr;
  logic              w_clr_last;
  logic              w_clr_step;
  logic [ADDR_W-1:0] w_a;
  logic [7:0]        w_dout;
  logic              w_ce_n;
  logic              w_oe_n;
  logic              w_we_n;

`ifdef SRAM_ARB_HOST_EN
  logic              r_hst_we;
  logic [ADDR_W-1:0] r_hst_addr;
  logic [7:0]        r_hst_din;
  logic [7:0]        r_hst_dout;
  logic              r_hst_ack;
  logic              r_conflict;
`else
  logic              w_unused_host;
`endif

  assign w_clr_step = (r_state == CLR_WRITE) && !w_clr_last;

  sram_clr_counter #(
    .ADDR_W (ADDR_W)
  ) u_clr_counter (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .start    (clr_start),
    .step     (w_clr_step),
    .mem_size (mem_size),
    .addr     (w_clr_addr),
    .last     (w_clr_last)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state <= CLR_SETUP;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_a    = w_clr_addr;
    w_dout = CLR_VALUE;
    w_ce_n = 1'b1;
    w_oe_n = 1'b1;
    w_we_n = 1'b1;
    case (r_state)
      CLR_SETUP: begin
        w_ce_n = 1'b0;
        w_next = CLR_WRITE;
      end
      CLR_WRITE: begin
        w_ce_n = 1'b0;
        w_we_n = 1'b0;
        if (w_clr_last) begin
          w_next = IDLE;
        end else begin
          w_next = CLR_SETUP;
        end
      end
      IDLE: begin
        w_a    = core_addr;
        w_dout = core_din;
        w_ce_n = core_ce_n;
        w_oe_n = core_oe_n;
        w_we_n = core_we_n;
`ifdef SRAM_ARB_HOST_EN
        if (hst_req && core_ce_n) begin
          w_next = HST_SETUP;
        end
`endif
      end
`ifdef SRAM_ARB_HOST_EN
      HST_SETUP, HST_ACCESS: begin
        w_a    = r_hst_addr;
        w_dout = r_hst_din;
        w_ce_n = 1'b0;
        w_oe_n = r_hst_we;
        w_we_n = ~r_hst_we;
        if (r_state == HST_SETUP) begin
          w_next = HST_ACCESS;
        end else begin
          w_next = IDLE;
        end
      end
`endif
      default: begin
        w_next = CLR_SETUP;
      end
    endcase
    if (clr_start) begin
      w_next = CLR_SETUP;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_busy      <= 1'b1;
      r_core_dout <= 8'h00;
    end else begin
      if (clr_start) begin
        r_busy <= 1'b1;
      end else if ((r_state == CLR_WRITE) && w_clr_last) begin
        r_busy <= 1'b0;
      end
      if (r_state == IDLE) begin
        r_core_dout <= sram_din;
      end
    end
  end

`ifdef SRAM_ARB_HOST_EN
  // Host request fields are captured every IDLE cycle so the access uses the values seen at grant.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_hst_we   <= 1'b0;
      r_hst_addr <= '0;
      r_hst_din  <= 8'h00;
      r_hst_dout <= 8'h00;
      r_hst_ack  <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      if (r_state == IDLE) begin
        r_hst_we   <= hst_we;
        r_hst_addr <= hst_addr;
        r_hst_din  <= hst_din;
      end
      r_hst_ack <= (r_state == HST_SETUP) && !clr_start;
      if ((r_state == HST_SETUP) && !clr_start && !r_hst_we) begin
        r_hst_dout <= sram_din;
      end
      if (((r_state == HST_SETUP) || (r_state == HST_ACCESS)) && !core_ce_n) begin
        r_conflict <= 1'b1;
      end
    end
  end

  assign hst_ack  = r_hst_ack;
  assign hst_dout = r_hst_dout;
  assign conflict = r_conflict;
`else
  assign w_unused_host = ^{hst_req, hst_we, hst_addr, hst_din};
  assign hst_ack       = 1'b0;
  assign hst_dout      = 8'h00;
  assign conflict      = 1'b0;
`endif

  assign busy      = r_busy;
  assign core_dout = (r_state == IDLE) ? sram_din : r_core_dout;
  assign sram_a    = w_a;
  assign sram_dout = w_dout;

  // Reset forces the strobes inactive immediately, not at the next edge.
  assign sram_ce_n = w_ce_n | reset;
  assign sram_oe_n = w_oe_n | reset;
  assign sram_we_n = w_we_n | reset;

endmodule

// File: tb/tb_sram_clear_arb.sv
// tb/tb_sram_clear_arb.sv - self-checking bench for sram_clear_arb with ADDR_W = 6
// Expectations follow SRAM_ARB_HOST_EN when it is defined for the build.
module tb_sram_clear_arb;

`ifdef SRAM_ARB_HOST_EN
  localparam bit HOST = 1'b1;
`else
  localparam bit HOST = 1'b0;
`endif
  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic          clk_sys;
  logic          reset;
  logic          clr_start;
  logic          mem_size;
  logic          busy;
  logic [AW-1:0] core_addr;
  logic [7:0]    core_din;
  logic [7:0]    core_dout;
  logic          core_ce_n;
  logic          core_oe_n;
  logic          core_we_n;
  logic          hst_req;
  logic          hst_we;
  logic [AW-1:0] hst_addr;
  logic [7:0]    hst_din;
  logic          hst_ack;
  logic [7:0]    hst_dout;
  logic [AW-1:0] sram_a;
  logic [7:0]    sram_dout;
  logic [7:0]    sram_din;
  logic          sram_ce_n;
  logic          sram_oe_n;
  logic          sram_we_n;
  logic          conflict;

  sram_clear_arb #(
    .ADDR_W    (AW),
    .CLR_VALUE (8'h00)
  ) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .clr_start (clr_start),
    .mem_size  (mem_size),
    .busy      (busy),
    .core_addr (core_addr),
    .core_din  (core_din),
    .core_dout (core_dout),
    .core_ce_n (core_ce_n),
    .core_oe_n (core_oe_n),
    .core_we_n (core_we_n),
    .hst_req   (hst_req),
    .hst_we    (hst_we),
    .hst_addr  (hst_addr),
    .hst_din   (hst_din),
    .hst_ack   (hst_ack),
    .hst_dout  (hst_dout),
    .sram_a    (sram_a),
    .sram_dout (sram_dout),
    .sram_din  (sram_din),
    .sram_ce_n (sram_ce_n),
    .sram_oe_n (sram_oe_n),
    .sram_we_n (sram_we_n),
    .conflict  (conflict)
  );

  initial begin
    clk_sys = 1'b0;
    forever #5 clk_sys = ~clk_sys;
  end

  // Behavioural SRAM plus a log of every write strobe it sees.
  typedef struct packed {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } wr_t;

  logic [7:0] mem [DEPTH];
  wr_t        wlog[$];

  always @(posedge clk_sys) begin
    if (!sram_ce_n && !sram_we_n) begin
      mem[sram_a] <= sram_dout;
      wlog.push_back({sram_a, sram_dout});
    end
  end

  assign sram_din = (!sram_ce_n && !sram_oe_n) ? mem[sram_a] : 8'h00;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic pulse_clr(input logic ms);
    mem_size  = ms;
    clr_start = 1'b1;
    @(posedge clk_sys); #1;
    clr_start = 1'b0;
  endtask

  // Counts edges until busy drops and checks the logged clear writes.
  task automatic sweep_check(input string name, input int exp_cycles, input int exp_bytes);
    int base;
    int n;
    int bad;
    base = wlog.size();
    n    = 0;
    bad  = 0;
    for (int c = 1; c <= 300; c++) begin
      @(posedge clk_sys); #1;
      if (!busy) begin
        n = c;
        break;
      end
    end
    check({name, "_cycles"}, 32'(n), 32'(exp_cycles));
    check({name, "_writes"}, 32'(wlog.size() - base), 32'(exp_bytes));
    for (int i = 0; i < exp_bytes && (base + i) < wlog.size(); i++) begin
      if (wlog[base + i].a != i[AW-1:0] || wlog[base + i].d != 8'h00) bad++;
    end
    check({name, "_addr_data"}, 32'(bad), 32'd0);
  endtask

  task automatic core_write(input logic [AW-1:0] a, input logic [7:0] d);
    core_ce_n = 1'b0; core_oe_n = 1'b1; core_we_n = 1'b0;
    core_addr = a; core_din = d;
    @(posedge clk_sys); #1;
    core_ce_n = 1'b1; core_we_n = 1'b1;
  endtask

  // Host transaction; lat is the cycle index at which ack was seen, -1 if never.
  task automatic host_op(input logic we, input logic [AW-1:0] a, input logic [7:0] d,
                         output int lat, output logic [7:0] rd);
    hst_req = 1'b1; hst_we = we; hst_addr = a; hst_din = d;
    lat = -1;
    rd  = 8'h00;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_sys);
      if (hst_ack) begin
        lat = c;
        rd  = hst_dout;
        break;
      end
      @(posedge clk_sys); #1;
    end
    if (lat < 0) rd = hst_dout;
    @(posedge clk_sys); #1;
    hst_req = 1'b0;
  endtask

  typedef struct {
    logic          ce_n;
    logic          oe_n;
    logic          we_n;
    logic [AW-1:0] addr;
    logic [7:0]    din;
    logic          chk;
    logic [7:0]    exp;
  } vec_t;

  vec_t       vecs[7];
  logic [7:0] shadow [DEPTH];

  initial begin
    int            lat;
    logic [7:0]    rd;
    int            bad;
    int            acks;
    int            n;
    int            hit;
    int            op;
    logic [AW-1:0] ra;
    logic [7:0]    rdat;

    reset = 1'b1; clr_start = 1'b0; mem_size = 1'b0;
    core_addr = '0; core_din = 8'h00; core_ce_n = 1'b1; core_oe_n = 1'b1; core_we_n = 1'b1;
    hst_req = 1'b0; hst_we = 1'b0; hst_addr = '0; hst_din = 8'h00;

    vecs[0] = '{1'b0, 1'b1, 1'b0, 6'h05, 8'hA5, 1'b0, 8'h00};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 6'h3F, 8'h5A, 1'b0, 8'h00};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 6'h00, 8'hC3, 1'b0, 8'h00};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 6'h05, 8'h11, 1'b1, 8'hA5};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 6'h3F, 8'h22, 1'b1, 8'h5A};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 6'h00, 8'h33, 1'b1, 8'hC3};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 6'h2A, 8'h44, 1'b0, 8'h00};

    // Reset state
    repeat (3) @(negedge clk_sys);
    check("rst_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n}), 32'b111);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_ack", 32'(hst_ack), 32'd0);
    check("rst_hst_dout", 32'(hst_dout), 32'd0);
    check("rst_conflict", 32'(conflict), 32'd0);

    // Power-on sweep of the full 2 MB map
    reset = 1'b0;
    sweep_check("por", 128, 64);

    // Core passthrough in IDLE
    for (int i = 0; i < 7; i++) begin
      core_ce_n = vecs[i].ce_n; core_oe_n = vecs[i].oe_n; core_we_n = vecs[i].we_n;
      core_addr = vecs[i].addr; core_din = vecs[i].din;
      @(negedge clk_sys);
      check($sformatf("vec%0d_sram", i), 32'({sram_a, sram_dout, sram_ce_n, sram_oe_n, sram_we_n}),
            32'({vecs[i].addr, vecs[i].din, vecs[i].ce_n, vecs[i].oe_n, vecs[i].we_n}));
      if (vecs[i].chk) check($sformatf("vec%0d_dout", i), 32'(core_dout), 32'(vecs[i].exp));
      @(posedge clk_sys); #1;
    end

    // 1 MB sweep leaves the upper half alone; core strobes ignored during it
    for (int i = 0; i < DEPTH; i++) core_write(i[AW-1:0], 8'hEE);
    core_ce_n = 1'b0; core_oe_n = 1'b0; core_we_n = 1'b1; core_addr = 6'h3F;
    @(negedge clk_sys);
    check("half_pre_dout", 32'(core_dout), 32'hEE);
    check("half_pre_busy", 32'(busy), 32'd0);
    pulse_clr(1'b1);
    check("half_busy_rise", 32'(busy), 32'd1);
    check("half_dout_hold", 32'(core_dout), 32'hEE);
    sweep_check("half", 64, 32);
    core_ce_n = 1'b1; core_oe_n = 1'b1;
    bad = 0;
    for (int i = 32; i < DEPTH; i++) if (mem[i] != 8'hEE) bad++;
    check("half_upper_untouched", 32'(bad), 32'd0);

    // Host read of a preloaded byte
    core_write(6'h05, 8'hA5);
    host_op(1'b0, 6'h05, 8'h00, lat, rd);
    check("hst_read_latency", 32'(lat), HOST ? 32'd2 : 32'hFFFF_FFFF);
    check("hst_read_data", 32'(rd), HOST ? 32'hA5 : 32'h00);

    // Core chip enable during HST_SETUP raises the sticky conflict flag
    hst_req = 1'b1; hst_we = 1'b0; hst_addr = 6'h07;
    @(posedge clk_sys); #1;
    core_ce_n = 1'b0;
    @(negedge clk_sys);
    check("conflict_pre", 32'(conflict), 32'd0);
    @(posedge clk_sys); #1;
    @(negedge clk_sys);
    check("conflict_set", 32'(conflict), 32'(HOST));
    @(posedge clk_sys); #1;
    hst_req = 1'b0; core_ce_n = 1'b1;
    @(posedge clk_sys); #1;

    // clr_start beats a simultaneous host request; host is re-granted after the sweep
    hst_req = 1'b1; hst_we = 1'b0; hst_addr = 6'h25;
    pulse_clr(1'b1);
    check("prio_busy", 32'(busy), 32'd1);
    acks = 0;
    n    = 0;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk_sys); #1;
      acks += 32'(hst_ack);
      if (!busy) begin
        n = c;
        break;
      end
    end
    check("prio_cycles", 32'(n), 32'd64);
    check("prio_no_ack", 32'(acks), 32'd0);
    @(negedge clk_sys);
    check("prio_ack_idle", 32'(hst_ack), 32'd0);
    @(posedge clk_sys);
    @(negedge clk_sys);
    check("prio_ack_setup", 32'(hst_ack), 32'd0);
    @(posedge clk_sys);
    @(negedge clk_sys);
    check("prio_ack", 32'(hst_ack), 32'(HOST));
    check("prio_dout", 32'(hst_dout), HOST ? 32'hEE : 32'h00);
    @(posedge clk_sys); #1;
    hst_req = 1'b0;
    check("conflict_sticky", 32'(conflict), 32'(HOST));

    // Randomised core and host traffic against a shadow copy of the memory
    pulse_clr(1'b0);
    sweep_check("rand_clr", 128, 64);
    for (int i = 0; i < DEPTH; i++) shadow[i] = 8'h00;
    for (int k = 0; k < 150; k++) begin
      op   = int'($urandom_range(0, 3));
      ra   = AW'($urandom_range(0, DEPTH - 1));
      rdat = 8'($urandom);
      case (op)
        0: begin
          core_write(ra, rdat);
          shadow[ra] = rdat;
        end
        1: begin
          core_ce_n = 1'b0; core_oe_n = 1'b0; core_we_n = 1'b1; core_addr = ra;
          @(negedge clk_sys);
          check($sformatf("rand%0d_core_rd", k), 32'(core_dout), 32'(shadow[ra]));
          @(posedge clk_sys); #1;
          core_ce_n = 1'b1; core_oe_n = 1'b1;
        end
        2: begin
          host_op(1'b1, ra, rdat, lat, rd);
          check($sformatf("rand%0d_hst_wr_lat", k), 32'(lat), HOST ? 32'd2 : 32'hFFFF_FFFF);
          if (HOST) shadow[ra] = rdat;
        end
        default: begin
          host_op(1'b0, ra, 8'h00, lat, rd);
          check($sformatf("rand%0d_hst_rd_lat", k), 32'(lat), HOST ? 32'd2 : 32'hFFFF_FFFF);
          check($sformatf("rand%0d_hst_rd", k), 32'(rd), HOST ? 32'(shadow[ra]) : 32'h00);
        end
      endcase
    end

    // Reset in the middle of a sweep
    pulse_clr(1'b0);
    hit = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk_sys);
      if (sram_a == 6'd20 && busy) begin
        hit = 1;
        break;
      end
    end
    check("midrst_reached_20", 32'(hit), 32'd1);
    reset = 1'b1;
    #1;
    check("midrst_strobes", 32'({sram_ce_n, sram_oe_n, sram_we_n}), 32'b111);
    check("midrst_busy", 32'(busy), 32'd1);
    check("midrst_conflict", 32'(conflict), 32'd0);
    check("midrst_hst_dout", 32'(hst_dout), 32'd0);
    @(negedge clk_sys);
    reset = 1'b0;
    sweep_check("midrst_restart", 128, 64);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/sram_clear_arb.md
SRAM_CLEAR_ARB -- requirements
Module: sram_clear_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 21, the SRAM address width in bits.
REQ-002 SHALL have parameter CLR_VALUE, default 8'h00, the byte written during a clear sweep.
REQ-003 SHALL have port clk_sys, input, 1 bit: the single system clock (28 MHz); all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port clr_start, input, 1 bit: one-cycle pulse requesting a full clear sweep.
REQ-006 SHALL have port mem_size, input, 1 bit: 0 selects 2 MB, 1 selects 1 MB; sampled at sweep start.
REQ-007 SHALL have port busy, output, 1 bit: high while a sweep runs; used as the core hard-reset hold.
REQ-008 SHALL have the following core requester ports:
- core_addr, input, ADDR_W bits.
- core_din, input, 8 bits.
- core_dout, output, 8 bits.
- core_ce_n, core_oe_n, core_we_n: inputs, 1 bit each, active-low.
REQ-009 SHALL have the following host requester ports:
- hst_req, input, 1 bit: level request.
- hst_we, input, 1 bit.
- hst_addr, input, ADDR_W bits.
- hst_din, input, 8 bits.
- hst_ack, output, 1 bit: one-cycle pulse.
- hst_dout, output, 8 bits.
REQ-010 SHALL have the following SRAM side ports:
- sram_a, output, ADDR_W bits.
- sram_dout, output, 8 bits.
- sram_din, input, 8 bits.
- sram_ce_n, sram_oe_n, sram_we_n: outputs, 1 bit each.
REQ-011 SHALL have port conflict, output, 1 bit: sticky flag, set when core_ce_n falls during a host access.

Function
REQ-012 SHALL implement states CLR_SETUP, CLR_WRITE, IDLE, HST_SETUP and HST_ACCESS.
REQ-013 SHALL behave as follows in IDLE:
- SRAM outputs follow the core ports combinationally.
- core_dout = sram_din.
REQ-014 SHALL clear in two cycles per byte:
- CLR_SETUP: sram_a = clr_addr, sram_ce_n = 0, sram_we_n = 1.
- CLR_WRITE: sram_we_n = 0, sram_dout = CLR_VALUE.
- Then increment clr_addr and return to CLR_SETUP.
REQ-015 SHALL set the sweep end address to 2^ADDR_W-1 when mem_size = 0, and to 2^(ADDR_W-1)-1 when mem_size = 1.
REQ-016 SHALL, after CLR_WRITE at the end address, go to IDLE, and deassert busy on that transition edge.
REQ-017 SHALL, on clr_start in any state, restart the sweep at clr_addr = 0 in CLR_SETUP, re-sample mem_size, and assert busy on the next cycle; any in-flight host access is aborted without hst_ack.
REQ-018 SHALL give clr_start priority over hst_req when both are asserted in the same cycle.
REQ-019 SHALL grant the host only from IDLE, when hst_req = 1 and core_ce_n = 1 in the same cycle.
REQ-020 SHALL complete a host access in two cycles:
- HST_SETUP drives the address and data with strobes low (oe for a read, we for a write).
- HST_ACCESS registers sram_din into hst_dout, pulses hst_ack for one cycle, and returns to IDLE.
REQ-021 SHALL hold hst_ack low unless a host access completes; the host holds hst_req until ack, and a request still high after ack is treated as a new request.
REQ-022 SHALL ignore core strobes during HST states and the sweep, and SHALL set conflict if core_ce_n = 0 is seen in HST_SETUP or HST_ACCESS.
REQ-023 SHALL clear conflict only on reset.
REQ-024 SHALL hold core_dout at its last value outside IDLE.

Reset
REQ-025 SHALL, while reset is high, drive:
- state = CLR_SETUP, clr_addr = 0, busy = 1, hst_ack = 0.
- hst_dout = 0, conflict = 0, mem_size sample = 0.
- sram_ce_n = sram_oe_n = sram_we_n = 1.
REQ-026 SHALL begin a full sweep on the first clk_sys edge after reset deasserts.
REQ-027 SHALL, if reset asserts mid-sweep or mid-host access, abort immediately and restart the sweep from address 0.

Configuration
REQ-028 SHALL compile in the host port and the HST states when the macro SRAM_ARB_HOST_EN is defined.
REQ-029 SHALL, when SRAM_ARB_HOST_EN is undefined:
- Ignore hst_req.
- Tie hst_ack = 0, hst_dout = 0 and conflict = 0.
- Have only the states CLR_SETUP, CLR_WRITE and IDLE.

Structure
REQ-030 SHALL declare the state enum, the CLR_* and HST_* state encodings, and the default CLR_VALUE in package sram_arb_pkg.
REQ-031 SHALL place the address counter with end-address compare in sub-module sram_clr_counter (inputs: start, step, mem_size; outputs: addr, last).

Verification
REQ-032 SHALL run the bench with ADDR_W = 6.
REQ-033 SHALL verify: deassert reset with mem_size = 0 -> 64 writes of 8'h00 on addresses 0..63, then busy falls on cycle 128.
REQ-034 SHALL verify: clr_start with mem_size = 1 -> 32 writes on addresses 0..31, then busy falls after 64 cycles; addresses 32..63 are untouched.
REQ-035 SHALL verify: in IDLE, hst_req = 1, hst_we = 0, hst_addr = 6'h05, SRAM model holding 8'hA5 -> hst_ack on the 2nd cycle with hst_dout = 8'hA5.
REQ-036 SHALL verify: clr_start and hst_req asserted in the same cycle -> sweep starts and no hst_ack appears until the sweep ends and the host is re-granted.
REQ-037 SHALL verify: core_ce_n = 0 during HST_SETUP -> conflict = 1, and it stays 1 until reset.
REQ-038 SHALL verify: reset asserted at clr_addr = 20 -> all strobes go to 1 asynchronously; after release the sweep restarts at address 0.
